// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one memory port between IFU and LSU.
// One transaction in flight; LSU MemOp is turned into access length and load extension.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_memop,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned OPW  = 3;
    localparam int unsigned LENW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    owner_e          last_grant_q, last_grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [OPW-1:0]  memop_q, memop_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [LENW-1:0] len_q, len_d;
    logic            req_valid_q, req_valid_d;
    logic            ifu_resp_valid_q, ifu_resp_valid_d;
    logic            lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DW-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic            ifu_win;
    logic            lsu_win;
    logic            capture_resp;

    // Access length in bytes from the MemOp size field.
    function automatic logic [LENW-1:0] len_of(input logic [OPW-1:0] op);
        case (op[1:0])
            2'b00:   return LENW'(1);
            2'b01:   return LENW'(2);
            default: return LENW'(4);
        endcase
    endfunction

    // Sign/zero extension of right-aligned load data.
    function automatic logic [DW-1:0] fmt_load(input logic [OPW-1:0] op, input logic [DW-1:0] d);
        case (op)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // On a tie the requester that did not win last time takes the port.
    assign ifu_win = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
    assign lsu_win = lsu_req_valid && !ifu_win;

    assign ifu_req_ready = (state_q == IDLE) && ifu_win;
    assign lsu_req_ready = (state_q == IDLE) && lsu_win;

    assign mem_req_valid  = req_valid_q;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_len        = len_q;
    assign mem_wdata      = wdata_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_rdata      = lsu_rdata_q;

    // Next-state and datapath capture.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        memop_d          = memop_q;
        wdata_d          = wdata_q;
        len_d            = len_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;
        capture_resp     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_req_ready) begin
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    memop_d      = 3'b010;
                    wdata_d      = '0;
                    len_d        = LENW'(4);
                    state_d      = ISSUE;
                end else if (lsu_req_ready) begin
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    memop_d      = lsu_memop;
                    wdata_d      = lsu_wdata;
                    len_d        = len_of(lsu_memop);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (mem_resp_valid) begin
                        capture_resp = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    capture_resp = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_resp) begin
            if (owner_q == OWN_IFU) begin
                ifu_rdata_d      = mem_rdata;
                ifu_resp_valid_d = 1'b1;
            end else begin
                lsu_rdata_d      = wen_q ? '0 : fmt_load(memop_q, mem_rdata);
                lsu_resp_valid_d = 1'b1;
            end
        end

        req_valid_d = (state_d == ISSUE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            owner_q          <= OWN_IFU;
            last_grant_q     <= OWN_LSU;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            memop_q          <= '0;
            wdata_q          <= '0;
            len_q            <= '0;
            req_valid_q      <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_grant_q     <= last_grant_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            memop_q          <= memop_d;
            wdata_q          <= wdata_d;
            len_q            <= len_d;
            req_valid_q      <= req_valid_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, response scoreboard and
// hand-written sequences for arbitration, reset-in-flight and spurious responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [2:0]  lsu_memop;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [2:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_memop      (lsu_memop),
        .lsu_wdata      (lsu_wdata),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_len        (mem_len),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    typedef struct {
        bit          is_lsu;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          is_lsu;
        logic [31:0] addr;
        bit          wen;
        logic [2:0]  memop;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          rdy_dly;
        int          rsp_dly;
        logic [2:0]  exp_len;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest accepted request.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: ifu_resp_valid=%0b lsu_resp_valid=%0b, expected no response at %0t",
                         ifu_resp_valid, lsu_resp_valid, $time);
            end else begin
                e = sb.pop_front();
                check("resp_both", 32'(ifu_resp_valid & lsu_resp_valid), 32'd0);
                check("resp_owner", 32'(lsu_resp_valid), 32'(e.is_lsu));
                check("resp_data", e.is_lsu ? lsu_rdata : ifu_rdata, e.rdata);
            end
        end
    end

    task automatic idle_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wen        = 1'b0;
        lsu_memop      = 3'b000;
        lsu_wdata      = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        check({tag, "_mem_len"}, 32'(mem_len), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ifu_resp_valid"}, 32'(ifu_resp_valid), 32'd0);
        check({tag, "_lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        // Ready follows arbitration even while held in reset; IFU wins the first tie.
        lsu_req_valid = 1'b1;
        #1;
        check("rst_lsu_ready_alone", 32'(lsu_req_ready), 32'd1);
        ifu_req_valid = 1'b1;
        #1;
        check("rst_tie_ifu_ready", 32'(ifu_req_ready), 32'd1);
        check("rst_tie_lsu_ready", 32'(lsu_req_ready), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one request through IDLE/ISSUE/WAIT/RESP; entered and left in IDLE at posedge+1.
    task automatic do_txn(input vec_t v);
        exp_t e;
        if (v.is_lsu) begin
            lsu_req_valid = 1'b1;
            lsu_addr      = v.addr;
            lsu_wen       = v.wen;
            lsu_memop     = v.memop;
            lsu_wdata     = v.wdata;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr      = v.addr;
        end
        #1;
        check("req_ready", 32'(v.is_lsu ? lsu_req_ready : ifu_req_ready), 32'd1);
        e.is_lsu = v.is_lsu;
        e.rdata  = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        for (int c = 0; c <= v.rdy_dly; c++) begin
            check("mem_req_valid", 32'(mem_req_valid), 32'd1);
            check("mem_addr", mem_addr, v.addr);
            check("mem_len", 32'(mem_len), 32'(v.exp_len));
            check("mem_wen", 32'(mem_wen), 32'(v.is_lsu && v.wen));
            if (v.is_lsu && v.wen) check("mem_wdata", mem_wdata, v.wdata);
            if (c == 0) begin
                ifu_req_valid = 1'b1;
                lsu_req_valid = 1'b1;
                #1;
                check("busy_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
            end
            if (c < v.rdy_dly) begin
                @(posedge clk);
                #1;
            end
        end
        mem_req_ready = 1'b1;
        if (v.rsp_dly == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = v.mrdata;
        end else begin
            mem_rdata = 32'hBAD0_BAD0;
        end
        @(posedge clk);
        #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (v.rsp_dly > 0) begin
            check("wait_req_valid", 32'(mem_req_valid), 32'd0);
            repeat (v.rsp_dly - 1) begin
                @(posedge clk);
                #1;
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = v.mrdata;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
        end
        check("resp_valid", 32'(v.is_lsu ? lsu_resp_valid : ifu_resp_valid), 32'd1);
        @(posedge clk);
        #1;
        check("resp_pulse", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        //         lsu  addr           wen memop   wdata          mrdata         rdy rsp len   exp_rdata
        vecs[0]  = '{0, 32'h8000_0000, 0, 3'b010, 32'h0,         32'h0000_0413, 0, 0, 3'd4, 32'h0000_0413};
        vecs[1]  = '{1, 32'h8000_2000, 0, 3'b000, 32'h0,         32'h0000_00F0, 0, 0, 3'd1, 32'hFFFF_FFF0};
        vecs[2]  = '{1, 32'h8000_2001, 0, 3'b100, 32'h0,         32'h0000_00F0, 0, 1, 3'd1, 32'h0000_00F0};
        vecs[3]  = '{1, 32'h8000_2002, 0, 3'b001, 32'h0,         32'h0000_8001, 1, 0, 3'd2, 32'hFFFF_8001};
        vecs[4]  = '{1, 32'h8000_2004, 0, 3'b101, 32'h0,         32'h0000_8001, 0, 2, 3'd2, 32'h0000_8001};
        vecs[5]  = '{1, 32'h8000_2008, 0, 3'b010, 32'h0,         32'hDEAD_BEEF, 1, 2, 3'd4, 32'hDEAD_BEEF};
        vecs[6]  = '{1, 32'h8000_1000, 1, 3'b001, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1, 3'd2, 32'h0000_0000};
        vecs[7]  = '{1, 32'h8000_200C, 0, 3'b110, 32'h0,         32'h8765_4321, 0, 0, 3'd4, 32'h8765_4321};
        vecs[8]  = '{1, 32'h8000_2010, 0, 3'b000, 32'h0,         32'hAAAA_AA7F, 0, 0, 3'd1, 32'h0000_007F};
        vecs[9]  = '{1, 32'h8000_2014, 1, 3'b010, 32'hCAFE_F00D, 32'h0000_0000, 0, 1, 3'd4, 32'h0000_0000};
        vecs[10] = '{1, 32'h8000_2018, 0, 3'b011, 32'h0,         32'h1357_9BDF, 0, 0, 3'd4, 32'h1357_9BDF};
        vecs[11] = '{0, 32'h8000_0004, 0, 3'b010, 32'h0,         32'hFFFF_0000, 2, 1, 3'd4, 32'hFFFF_0000};

        do_reset();

        // Both requesters valid from reset: grants alternate starting with the IFU.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        lsu_memop     = 3'b010;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            #1;
            check("rr_ifu_ready", 32'(ifu_req_ready), 32'((k % 2) == 0));
            check("rr_lsu_ready", 32'(lsu_req_ready), 32'((k % 2) == 1));
            e.is_lsu = ((k % 2) == 1);
            e.rdata  = 32'h0000_1000 + 32'(k);
            sb.push_back(e);
            @(posedge clk);
            #1;
            check("rr_mem_addr", mem_addr, ((k % 2) == 0) ? 32'h8000_0100 : 32'h8000_0200);
            check("rr_mem_len", 32'(mem_len), 32'd4);
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'h0000_1000 + 32'(k);
            @(posedge clk);
            #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            @(posedge clk);
        end
        #1;
        idle_inputs();

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
        end

        // Spurious memory response while idle changes nothing.
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h2222_2222;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        check("spur_req_valid", 32'(mem_req_valid), 32'd0);
        check("spur_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
        check("spur_ifu_rdata", ifu_rdata, vecs[11].exp_rdata);
        check("spur_lsu_rdata", lsu_rdata, vecs[10].exp_rdata);
        do_txn(vecs[0]);

        // Reset while waiting for the memory; the late response must be dropped.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        check("rw_issue", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        check("rw_wait", 32'(mem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rw");
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1111_1111;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        check("rw_late_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
        check("rw_late_req_valid", 32'(mem_req_valid), 32'd0);
        check("rw_late_ifu_rdata", ifu_rdata, 32'd0);
        do_txn(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
